// File: rtl/ttl74x469_updown_counter.sv
// ttl74x469_updown_counter: synchronous presettable up/down binary counter
// with programmable modulus, active-low cascade carry/borrow and a sticky
// wrap flag.
// Optional feature macro: TTL469_COMPARE_EN
//   Defined   -> adds a WIDTH-bit compare register, the CMP_LD input and
//                the MATCH output.
//   Undefined -> plain counter; CMP_LD/MATCH and the compare register are absent.
// Mode encoding on M: 00 clear, 01 count down, 10 parallel load, 11 count up.
module ttl74x469_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [1:0]       M,
  input  logic             CI_n,
  input  logic [WIDTH-1:0] D,
  input  logic             OE,
  output logic [WIDTH-1:0] Q,
  output logic             CO_n,
  output logic             WRAP
`ifdef TTL469_COMPARE_EN
  ,
  input  logic             CMP_LD,
  output logic             MATCH
`endif
);

  // Terminal value: MODULUS-1, or all ones when the full 2^WIDTH range is used.
  localparam logic [WIDTH-1:0] TOP =
    (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] M_CLR  = 2'b00;
  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_LOAD = 2'b10;
  localparam logic [1:0] M_UP   = 2'b11;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             at_top, at_zero;

  // Values above TOP (reachable only by load) count as terminal when counting up.
  assign at_top  = (count_q >= TOP);
  assign at_zero = (count_q == '0);

  // Next-state selection by mode; CLR is applied in the register block.
  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    unique case (M)
      M_CLR: begin
        count_d = '0;
        wrap_d  = 1'b0;
      end
      M_LOAD: count_d = D;
      M_UP: begin
        if (!CI_n) begin
          if (at_top) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
      end
      M_DOWN: begin
        if (!CI_n) begin
          if (at_zero) begin
            count_d = TOP;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - ONE;
          end
        end
      end
      default: ;
    endcase
  end

  // Count and sticky wrap registers; synchronous reset has priority over M.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Carry/borrow out is low exactly in the cycles that wrap at the next edge.
  assign CO_n = ~(~CI_n & (((M == M_UP) & at_top) | ((M == M_DOWN) & at_zero)));

  // OE only gates the visible value; state is untouched.
  assign Q    = OE ? count_q : '0;
  assign WRAP = wrap_q;

`ifdef TTL469_COMPARE_EN
  logic [WIDTH-1:0] cmp_q;

  // Compare register loads from D independently of the counter mode.
  always_ff @(posedge CLK) begin
    if (CLR)         cmp_q <= '0;
    else if (CMP_LD) cmp_q <= D;
  end

  // Match is taken on the raw count, so it ignores OE.
  assign MATCH = (count_q == cmp_q);
`endif

endmodule

// File: tb/tb_ttl74x469_updown_counter.sv
// Scoreboard bench for ttl74x469_updown_counter.
// Three views driven by the same control inputs:
//   A: WIDTH=8, MODULUS=0 (full range, optional compare unit)
//   B: WIDTH=4, MODULUS=10
//   C: two cascaded WIDTH=4 stages, modelled as one 8-bit counter
// The driver pushes expected outputs into a queue; the monitor pops and
// compares one entry after each rising edge.
module tb_ttl74x469_updown_counter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       CLR = 1'b1, CI_n = 1'b0, OE = 1'b1, CMP_LD = 1'b0;
  logic [1:0] M = 2'b00;
  logic [7:0] D = 8'h00;

  wire [7:0] qa;
  wire       coa, wra;
  wire [3:0] qb;
  wire       cob, wrb;
  wire [3:0] qlo, qhi;
  wire       colo, cohi, wrlo, wrhi;
`ifdef TTL469_COMPARE_EN
  wire       mta, mtb, mtlo, mthi;
`endif

  ttl74x469_updown_counter #(.WIDTH(8), .MODULUS(0)) u_a (
    .CLK(CLK), .CLR(CLR), .M(M), .CI_n(CI_n), .D(D), .OE(OE),
    .Q(qa), .CO_n(coa), .WRAP(wra)
`ifdef TTL469_COMPARE_EN
    , .CMP_LD(CMP_LD), .MATCH(mta)
`endif
  );

  ttl74x469_updown_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .CLK(CLK), .CLR(CLR), .M(M), .CI_n(CI_n), .D(D[3:0]), .OE(OE),
    .Q(qb), .CO_n(cob), .WRAP(wrb)
`ifdef TTL469_COMPARE_EN
    , .CMP_LD(1'b0), .MATCH(mtb)
`endif
  );

  ttl74x469_updown_counter #(.WIDTH(4), .MODULUS(0)) u_lo (
    .CLK(CLK), .CLR(CLR), .M(M), .CI_n(CI_n), .D(D[3:0]), .OE(OE),
    .Q(qlo), .CO_n(colo), .WRAP(wrlo)
`ifdef TTL469_COMPARE_EN
    , .CMP_LD(1'b0), .MATCH(mtlo)
`endif
  );

  ttl74x469_updown_counter #(.WIDTH(4), .MODULUS(0)) u_hi (
    .CLK(CLK), .CLR(CLR), .M(M), .CI_n(colo), .D(D[7:4]), .OE(OE),
    .Q(qhi), .CO_n(cohi), .WRAP(wrhi)
`ifdef TTL469_COMPARE_EN
    , .CMP_LD(1'b0), .MATCH(mthi)
`endif
  );

  typedef struct {
    int qa; bit coa; bit wra; bit mta;
    int qb; bit cob; bit wrb;
    int qc; bit coc; bit wrc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: plain integers following the counting rules.
  int ca = 0, cb = 0, cc = 0, cmp = 0;
  bit wa = 0, wb = 0, wc = 0;

  function automatic bit ref_co_n(int cnt, int top, logic [1:0] m, bit ci);
    return !(!ci && ((m == 2'b11 && cnt >= top) || (m == 2'b01 && cnt == 0)));
  endfunction

  task automatic ref_adv(input int top, input int d, input logic [1:0] m,
                         input bit ci, inout int cnt, inout bit w);
    case (m)
      2'b00: begin cnt = 0; w = 0; end
      2'b10: cnt = d;
      2'b11: if (!ci) begin
               if (cnt >= top) begin cnt = 0; w = 1; end
               else cnt = cnt + 1;
             end
      default: if (!ci) begin
               if (cnt == 0) begin cnt = top; w = 1; end
               else cnt = cnt - 1;
             end
    endcase
  endtask

  // Apply one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input bit clr, input logic [1:0] m, input bit ci,
                      input int d, input bit oe, input bit ld);
    exp_t e;
    @(negedge CLK);
    CLR = clr; M = m; CI_n = ci; D = d[7:0]; OE = oe; CMP_LD = ld;
    if (clr) begin
      ca = 0; cb = 0; cc = 0; cmp = 0; wa = 0; wb = 0; wc = 0;
    end else begin
      if (ld) cmp = d & 255;
      ref_adv(255, d & 255, m, ci, ca, wa);
      ref_adv(9,   d & 15,  m, ci, cb, wb);
      ref_adv(255, d & 255, m, ci, cc, wc);
    end
    e.qa  = oe ? ca : 0;
    e.coa = ref_co_n(ca, 255, m, ci);
    e.wra = wa;
    e.mta = (ca == cmp);
    e.qb  = oe ? cb : 0;
    e.cob = ref_co_n(cb, 9, m, ci);
    e.wrb = wb;
    e.qc  = oe ? cc : 0;
    e.coc = ref_co_n(cc, 255, m, ci);
    e.wrc = wc;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, want);
    end
  endtask

  // Monitor: compare one queued expectation after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("qa",   32'(qa),   32'(e.qa));
        chk("coa",  32'(coa),  32'(e.coa));
        chk("wra",  32'(wra),  32'(e.wra));
`ifdef TTL469_COMPARE_EN
        chk("mta",  32'(mta),  32'(e.mta));
`endif
        chk("qb",   32'(qb),   32'(e.qb));
        chk("cob",  32'(cob),  32'(e.cob));
        chk("wrb",  32'(wrb),  32'(e.wrb));
        chk("qc",   32'({qhi, qlo}), 32'(e.qc));
        chk("coc",  32'(cohi), 32'(e.coc));
        chk("wrc",  32'(wrhi), 32'(e.wrc));
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int r;
    logic [1:0] m;

    // Reset, including reset while counting down from 0 (CO_n low).
    step(1, 2'b11, 0, 0, 1, 0);
    step(1, 2'b01, 0, 0, 1, 0);

    // Full up-count through 0x0F->0x10 and 0xFF->0x00.
    for (int i = 0; i < 258; i++) step(0, 2'b11, 0, 0, 1, 0);

    // Down-count from 0 on the mod-10 view: wraps to 9 on the first edge.
    step(1, 2'b11, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 2'b01, 0, 0, 1, 0);

    // Load above TOP, then count up / down.
    step(1, 2'b00, 0, 0, 1, 0);
    step(0, 2'b10, 0, 13, 1, 0);
    step(0, 2'b11, 0, 13, 1, 0);
    step(0, 2'b11, 0, 13, 1, 0);
    step(1, 2'b00, 0, 0, 1, 0);
    step(0, 2'b10, 1, 13, 1, 0);
    step(0, 2'b01, 0, 13, 1, 0);

    // CLR beats load; hold with CI_n high; OE gating while counting.
    step(1, 2'b10, 0, 8'hA5, 1, 0);
    step(0, 2'b10, 0, 8'h3C, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 2'b11, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 2'b11, 0, 0, 0, 0);
    step(0, 2'b11, 1, 0, 1, 0);

    // Compare register: load 7 while clearing, then count past it.
    step(0, 2'b00, 0, 7, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 2'b11, 0, 0, 1, 0);
    step(0, 2'b10, 0, 3, 1, 1);
    step(0, 2'b11, 1, 0, 1, 0);

    // Randomized traffic biased toward counting.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       m = 2'b00;
      else if (r < 12) m = 2'b10;
      else if (r < 56) m = 2'b11;
      else             m = 2'b01;
      step($urandom_range(0, 63) == 0, m, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 255)), $urandom_range(0, 9) != 0,
           $urandom_range(0, 15) == 0);
    end

    repeat (3) @(negedge CLK);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
